// File: rtl/pov_column_mapper.sv
// Maps rotor angle plus LED-index requests to texture ROM addresses and returns
// brightness/invert-adjusted GRB pixels, with tear-free config shadowing per revolution.
module pov_column_mapper #(
  parameter int LED_COUNT    = 52,
  parameter int TEX_WIDTH    = 128,
  parameter int NUM_TEXTURES = 3,
  parameter int THETA_BITS   = 6,
  parameter int PX_BITS      = 6,
  parameter int ROM_LATENCY  = 1,
  parameter int ADDR_BITS    = $clog2(LED_COUNT * TEX_WIDTH * NUM_TEXTURES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [THETA_BITS-1:0]        theta,
  input  logic                         px_req,
  input  logic [PX_BITS-1:0]           px_idx,
  output logic [ADDR_BITS-1:0]         rom_addr,
  input  logic [23:0]                  rom_data,
  input  logic [3:0]                   cfg_texture_idx,
  input  logic [$clog2(TEX_WIDTH)-1:0] cfg_col_offset,
  input  logic [7:0]                   cfg_brightness,
  input  logic                         cfg_invert,
  output logic                         px_valid,
  output logic [23:0]                  px_data,
  output logic                         frame_wrap
);

  localparam int COL_BITS  = $clog2(TEX_WIDTH);
  localparam int PROD_BITS = THETA_BITS + COL_BITS + 1;

  // Per-request attributes that travel alongside the ROM access.
  typedef struct packed {
    logic       valid;
    logic       oor;
    logic [7:0] bright;
    logic       inv;
  } meta_t;

  logic [THETA_BITS-1:0] theta_lat_q, theta_lat_d;
  logic                  first_col_q, first_col_d;
  logic [3:0]            sh_tex_q, sh_tex_d;
  logic [COL_BITS-1:0]   sh_off_q, sh_off_d;
  logic [7:0]            sh_bright_q, sh_bright_d;
  logic                  sh_inv_q, sh_inv_d;
  logic [ADDR_BITS-1:0]  rom_addr_q, rom_addr_d;
  logic                  frame_wrap_q, frame_wrap_d;
  logic                  px_valid_q, px_valid_d;
  logic [23:0]           px_data_q, px_data_d;
  meta_t                 meta_q [ROM_LATENCY+1];
  meta_t                 meta_d [ROM_LATENCY+1];

  logic                  is_col0;
  logic                  wrap;
  logic                  oor;
  logic [THETA_BITS-1:0] theta_use;
  logic [PROD_BITS-1:0]  col_prod;
  logic [COL_BITS-1:0]   col;
  logic [23:0]           px_res;

  function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [7:0] bright,
                                            input logic inv);
    logic [7:0]  s;
    logic [15:0] prod;
    s    = inv ? ~c : c;
    prod = 16'(s) * (16'(bright) + 16'd1);
    return 8'(prod >> 8);
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    theta_lat_d  = theta_lat_q;
    first_col_d  = first_col_q;
    sh_tex_d     = sh_tex_q;
    sh_off_d     = sh_off_q;
    sh_bright_d  = sh_bright_q;
    sh_inv_d     = sh_inv_q;
    rom_addr_d   = rom_addr_q;
    px_data_d    = px_data_q;
    px_res       = '0;

    is_col0      = px_req && (px_idx == '0);
    wrap         = is_col0 && ((theta < theta_lat_q) || first_col_q);
    frame_wrap_d = wrap;

    if (is_col0) theta_lat_d = theta;

    // The wrapping request itself must already see the freshly loaded config.
    if (wrap) begin
      first_col_d = 1'b0;
      sh_tex_d    = (int'(cfg_texture_idx) >= NUM_TEXTURES) ? 4'd0 : cfg_texture_idx;
      sh_off_d    = cfg_col_offset;
      sh_bright_d = cfg_brightness;
      sh_inv_d    = cfg_invert;
    end

    theta_use = is_col0 ? theta : theta_lat_q;
    col_prod  = (PROD_BITS'(theta_use) * PROD_BITS'(TEX_WIDTH)) >> THETA_BITS;
    col       = COL_BITS'(col_prod + PROD_BITS'(sh_off_d));
    oor       = int'(px_idx) >= LED_COUNT;

    if (px_req) begin
      rom_addr_d = oor ? '0 :
                   ADDR_BITS'(32'(px_idx) * 32'(TEX_WIDTH * NUM_TEXTURES)
                              + 32'(sh_tex_d) * 32'(TEX_WIDTH) + 32'(col));
    end

    meta_d[0] = '{valid: px_req, oor: oor, bright: sh_bright_d, inv: sh_inv_d};
    for (int k = 1; k <= ROM_LATENCY; k++) meta_d[k] = meta_q[k-1];

    // Stage C: meta_q[ROM_LATENCY] lines up with the rom_data it belongs to.
    for (int ch = 0; ch < 3; ch++) begin
      px_res[ch*8 +: 8] = scale_byte(rom_data[ch*8 +: 8], meta_q[ROM_LATENCY].bright,
                                     meta_q[ROM_LATENCY].inv);
    end
    if (meta_q[ROM_LATENCY].oor) px_res = '0;

    px_valid_d = meta_q[ROM_LATENCY].valid;
    if (meta_q[ROM_LATENCY].valid) px_data_d = px_res;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      theta_lat_q  <= '0;
      first_col_q  <= 1'b1;
      sh_tex_q     <= '0;
      sh_off_q     <= '0;
      sh_bright_q  <= 8'd255;
      sh_inv_q     <= 1'b0;
      rom_addr_q   <= '0;
      frame_wrap_q <= 1'b0;
      px_valid_q   <= 1'b0;
      px_data_q    <= '0;
      // NOTE: the pipeline is only a few flops, so it is cleared to drop in-flight requests.
      for (int k = 0; k <= ROM_LATENCY; k++) meta_q[k] <= '0;
    end else begin
      theta_lat_q  <= theta_lat_d;
      first_col_q  <= first_col_d;
      sh_tex_q     <= sh_tex_d;
      sh_off_q     <= sh_off_d;
      sh_bright_q  <= sh_bright_d;
      sh_inv_q     <= sh_inv_d;
      rom_addr_q   <= rom_addr_d;
      frame_wrap_q <= frame_wrap_d;
      px_valid_q   <= px_valid_d;
      px_data_q    <= px_data_d;
      for (int k = 0; k <= ROM_LATENCY; k++) meta_q[k] <= meta_d[k];
    end
  end

  assign rom_addr   = rom_addr_q;
  assign frame_wrap = frame_wrap_q;
  assign px_valid   = px_valid_q;
  assign px_data    = px_data_q;

endmodule

// File: tb/tb_pov_column_mapper.sv
// Scoreboard bench for pov_column_mapper: directed requests push expected address/pixel,
// monitors pop and compare whenever the DUT presents rom_addr or px_valid.
module tb_pov_column_mapper;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    theta;
  logic          px_req;
  logic [5:0]    px_idx;
  logic [AW-1:0] rom_addr;
  logic [23:0]   rom_data;
  logic [3:0]    cfg_texture_idx;
  logic [6:0]    cfg_col_offset;
  logic [7:0]    cfg_brightness;
  logic          cfg_invert;
  logic          px_valid;
  logic [23:0]   px_data;
  logic          frame_wrap;

  always #5 clk = ~clk;

  pov_column_mapper dut (
    .clk             (clk),
    .reset           (reset),
    .theta           (theta),
    .px_req          (px_req),
    .px_idx          (px_idx),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .cfg_texture_idx (cfg_texture_idx),
    .cfg_col_offset  (cfg_col_offset),
    .cfg_brightness  (cfg_brightness),
    .cfg_invert      (cfg_invert),
    .px_valid        (px_valid),
    .px_data         (px_data),
    .frame_wrap      (frame_wrap)
  );

  typedef struct {
    logic [23:0] data;
    int          cyc;
  } exp_t;

  exp_t          data_q[$];
  logic [AW-1:0] addr_q[$];
  logic [23:0]   rom_ovr[int];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   wrap_cnt = 0;
  int   valid_run = 0;
  int   max_run = 0;
  int   post_reset_valids = 0;
  logic req_d1 = 1'b0;

  function automatic logic [23:0] rom_word(input logic [AW-1:0] a);
    if (rom_ovr.exists(int'(a))) return rom_ovr[int'(a)];
    return {a[7:0], a[14:7] ^ 8'h3C, ~a[7:0]};
  endfunction

  // Texture ROM with one cycle of latency, plus bookkeeping taps.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    req_d1   <= px_req && !reset;
    rom_data <= rom_word(rom_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        valid_run = 0;
      end else begin
        if (frame_wrap) wrap_cnt++;
        if (req_d1) begin
          if (addr_q.size() == 0) check("rom_addr_unexpected", 1, 0);
          else check("rom_addr", 32'(rom_addr), 32'(addr_q.pop_front()));
        end
        if (px_valid) begin
          valid_run++;
          if (valid_run > max_run) max_run = valid_run;
          post_reset_valids++;
          if (data_q.size() == 0) begin
            check("px_valid_unexpected", 1, 0);
          end else begin
            e = data_q.pop_front();
            check("px_data", 32'(px_data), 32'(e.data));
            check("latency", cyc - e.cyc, 3);
          end
        end else begin
          valid_run = 0;
        end
      end
    end
  end

  task automatic issue(input int idx, input int th, input int exp_addr,
                       input logic [23:0] exp_data);
    exp_t e;
    px_req = 1'b1;
    px_idx = 6'(idx);
    theta  = 6'(th);
    e.data = exp_data;
    e.cyc  = cyc;
    data_q.push_back(e);
    addr_q.push_back(AW'(exp_addr));
    @(posedge clk); #1;
    px_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((data_q.size() != 0 || addr_q.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", data_q.size() + addr_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    px_req = 1'b0; px_idx = '0; theta = '0;
    cfg_texture_idx = 4'd0; cfg_col_offset = 7'd0; cfg_brightness = 8'd255; cfg_invert = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_px_valid", 32'(px_valid), 0);
    check("reset_px_data", 32'(px_data), 0);
    check("reset_rom_addr", 32'(rom_addr), 0);
    check("reset_frame_wrap", 32'(frame_wrap), 0);

    // First idx-0 after reset wraps; pass-through at unity brightness.
    rom_ovr[16] = 24'h112233;
    issue(0, 8, 16, 24'h112233);
    drain();
    check("wrap_count_first", wrap_cnt, 1);

    // Texture 1, then snapshot: idx 2 uses theta_lat=32 regardless of theta input.
    cfg_texture_idx = 4'd1;
    issue(0, 4, 136, rom_word(136));
    issue(0, 32, 192, rom_word(192));
    issue(2, 5, 960, rom_word(960));
    drain();
    check("wrap_count_tex1", wrap_cnt, 2);

    // Column scroll: (2*40 + 100) mod 128 = 52.
    cfg_col_offset = 7'd100;
    issue(0, 10, 248, rom_word(248));
    issue(0, 40, 180, rom_word(180));
    issue(1, 0, 564, rom_word(564));
    drain();
    check("wrap_count_scroll", wrap_cnt, 3);

    // Brightness 127 with inversion.
    cfg_col_offset = 7'd0; cfg_texture_idx = 4'd0; cfg_brightness = 8'd127; cfg_invert = 1'b1;
    rom_ovr[4]    = 24'h00FF80;
    rom_ovr[1156] = 24'hFF8000;
    issue(0, 2, 4, 24'h7F003F);
    issue(3, 0, 1156, 24'h003F7F);
    drain();
    check("wrap_count_colour", wrap_cnt, 4);

    // Mid-revolution config change stays invisible until theta drops below theta_lat.
    cfg_texture_idx = 4'd2; cfg_brightness = 8'd255; cfg_invert = 1'b0;
    rom_ovr[388] = 24'h000000;
    rom_ovr[10]  = 24'h808080;
    issue(1, 9, 388, 24'h7F7F7F);
    issue(0, 5, 10, 24'h3F3F3F);
    drain();
    check("wrap_count_midrev", wrap_cnt, 4);
    issue(0, 1, 258, rom_word(258));
    drain();
    check("wrap_count_newtex", wrap_cnt, 5);

    // Out-of-range texture index selects texture 0.
    cfg_texture_idx = 4'd7;
    issue(0, 0, 0, rom_word(0));
    issue(1, 0, 384, rom_word(384));
    drain();
    check("wrap_count_tex7", wrap_cnt, 6);

    // Full strip back-to-back plus one out-of-range LED index.
    max_run = 0;
    issue(0, 3, 6, rom_word(6));
    for (int i = 1; i < 52; i++) issue(i, 0, i * 384 + 6, rom_word(AW'(i * 384 + 6)));
    issue(60, 0, 0, 24'h000000);
    drain();
    check("run_length", max_run, 53);
    check("wrap_count_strip", wrap_cnt, 6);

    // Reset with two requests in flight.
    issue(5, 0, 1926, rom_word(1926));
    issue(5, 0, 1926, rom_word(1926));
    reset = 1'b1;
    data_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    post_reset_valids = 0;
    check("reset2_rom_addr", 32'(rom_addr), 0);
    check("reset2_frame_wrap", 32'(frame_wrap), 0);
    repeat (8) @(posedge clk);
    #1;
    check("valids_after_reset", post_reset_valids, 0);

    // first_col is set again after reset: next idx-0 wraps even at a higher theta.
    issue(0, 20, 40, rom_word(40));
    drain();
    check("wrap_count_after_reset", wrap_cnt, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
